// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared 32-bit memory port (req0 = fetch, req1 = data).
// Ports: clk, rst_n (sync, active-low); per-requester req/addr/wdata/we in,
// done out; shared rdata/err/busy out; memory side mem_sel/mem_valid/
// mem_addr/mem_wdata/mem_we out, mem_ready/mem_rdata in.
// Build option: define ARB_RR_EN for round-robin ties (default: req1 wins).
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_sel,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic       win;

`ifdef ARB_RR_EN
  logic last;

  // On a tie the requester not granted last time wins.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last;
  end
`else
  always_comb begin
    win = req1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_sel   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
`ifdef ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          err   <= 1'b0;
          if (req0 || req1) begin
            state     <= BUSY;
            cnt       <= '0;
            busy      <= 1'b1;
            mem_valid <= 1'b1;
            mem_sel   <= win;
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
            mem_we    <= win ? we1 : we0;
`ifdef ARB_RR_EN
            last      <= win;
`endif
          end
        end
        BUSY: begin
          // Completion beats timeout on the same edge.
          if (mem_ready) begin
            state     <= DONE;
            mem_valid <= 1'b0;
            rdata     <= mem_we ? '0 : mem_rdata;
            err       <= 1'b0;
            done0     <= ~mem_sel;
            done1     <= mem_sel;
          end else if (cnt == TO) begin
            state     <= DONE;
            mem_valid <= 1'b0;
            rdata     <= '0;
            err       <= 1'b1;
            done0     <= ~mem_sel;
            done1     <= mem_sel;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done0 <= 1'b0;
          done1 <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random
// transactions checked against a per-transaction reference model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        we0, we1;
  logic        done0, done1;
  logic [31:0] rdata;
  logic        err, busy, mem_sel, mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic last_m = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_sel(mem_sel), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_done"}, {30'd0, done1, done0}, 32'd0);
    chk({tag, "_flags"}, {27'd0, err, busy, mem_sel, mem_valid, mem_we},
        32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk_zero_outs("reset");
    end
    rst_n = 1'b1;
    last_m = 1'b1;
  endtask

  // One transaction from an IDLE cycle: waits = number of mem_ready-low
  // BUSY edges before ready; waits > TO means ready never comes.
  task automatic txn(input logic r0, input logic r1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] w0, input logic [31:0] w1,
                     input logic e0, input logic e1,
                     input int waits, input logic [31:0] rd);
    logic        win;
    logic [31:0] ea, ew, er;
    logic        ee, eerr;
    int          fin;
`ifdef ARB_RR_EN
    win = (r0 && r1) ? ~last_m : r1;
`else
    win = r1;
`endif
    last_m = win;
    ea = win ? a1 : a0;
    ew = win ? w1 : w0;
    ee = win ? e1 : e0;
    eerr = (waits > TO);
    fin = eerr ? TO + 1 : waits + 1;
    er = (eerr || ee) ? 32'd0 : rd;

    req0 = r0; req1 = r1;
    addr0 = a0; addr1 = a1;
    wdata0 = w0; wdata1 = w1;
    we0 = e0; we1 = e1;
    mem_ready = 1'($urandom);
    @(posedge clk); #1;
    chk("grant_sel", {31'd0, mem_sel}, {31'd0, win});
    for (int k = 1; k <= fin; k++) begin
      chk("valid", {31'd0, mem_valid}, 32'd1);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("addr", mem_addr, ea);
      chk("wdata", mem_wdata, ew);
      chk("we_sel", {30'd0, mem_we, mem_sel}, {30'd0, ee, win});
      chk("no_early_done", {30'd0, done1, done0}, 32'd0);
      mem_ready = !eerr && (k == fin);
      mem_rdata = mem_ready ? rd : $urandom;
      @(posedge clk); #1;
    end
    chk("done", {30'd0, done1, done0}, win ? 32'd2 : 32'd1);
    chk("err", {31'd0, err}, {31'd0, eerr});
    chk("rdata", rdata, er);
    chk("done_valid", {30'd0, busy, mem_valid}, 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    mem_ready = 1'($urandom);
    @(posedge clk); #1;
    chk("idle", {28'd0, done1, done0, busy, mem_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b0;
    addr0 = 32'h40; addr1 = '0;
    wdata0 = '0; wdata1 = '0;
    we0 = 1'b0; we1 = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;

    do_reset(2);

    txn(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);

    do_reset(1);
    txn(1, 1, 32'h100, 32'h200, 32'h1, 32'h2, 0, 0, 0, 32'hA5A5A5A5);
    txn(1, 1, 32'h104, 32'h204, 32'h3, 32'h4, 0, 1, 1, 32'h5A5A5A5A);

    txn(0, 1, 0, 32'h300, 0, 32'h12345678, 0, 1, 3, 32'hCAFEF00D);

    txn(1, 0, 32'h500, 0, 0, 0, 0, 0, 100, 32'hBAD0BAD0);
    txn(1, 0, 32'h504, 0, 0, 0, 0, 0, TO, 32'h600DF00D);

    req1 = 1'b1; addr1 = 32'h700; wdata1 = '0; we1 = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", {31'd0, mem_valid}, 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    do_reset(1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_reset_idle", {29'd0, done1, done0, busy}, 32'd0);
    end
    txn(0, 1, 0, 32'h704, 0, 0, 0, 0, 1, 32'h0BADCAFE);

    for (int i = 0; i < 40; i++) begin
      logic r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      txn(r0, r1, $urandom, $urandom, $urandom, $urandom,
          1'($urandom), 1'($urandom), $urandom_range(0, 6), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
